xalu_iter: RTL and testbench

//  Parametrised iterative multiply/divide unit: successor to the fixed-latency HI/LO unit in the EX stage.

---
 rtl/xalu_iter.sv | 154 +++++++++++++++
 tb/tb_xalu_iter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xalu_iter.sv
// Iterative mult/multu/div/divu unit with HI/LO commit, plus mthi/mtlo/mfhi/mflo.
// Latency: ops 1,2,7,8 hold Busy for WIDTH+1 cycles; mthi/mtlo commit at accept; mfhi/mflo combinational.
// Backpressure: Start while Busy is dropped (no queueing); Flush aborts the in-flight op without commit.
module xalu_iter #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    input  logic [OP_W-1:0]  XALUOp,
    input  logic             Start,
    input  logic             Flush,
    output logic [WIDTH-1:0] XALU_Out,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [OP_W-1:0] OP_MULT  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'(2);
    localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_MFHI  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_MFLO  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_DIV   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(8);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi, lo;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] prod;
    logic               is_div, neg_lo, neg_hi;

    logic               op_long, op_div, op_sgn, div_zero;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, mul_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign Busy = (state != S_IDLE);

    always_comb begin
        op_div   = (XALUOp == OP_DIV) || (XALUOp == OP_DIVU);
        op_long  = op_div || (XALUOp == OP_MULT) || (XALUOp == OP_MULTU);
        op_sgn   = (XALUOp == OP_MULT) || (XALUOp == OP_DIV);
        div_zero = op_div && (D2 == '0);
        a_neg    = op_sgn && D1[WIDTH-1];
        b_neg    = op_sgn && D2[WIDTH-1];
        a_mag    = a_neg ? -D1 : D1;
        b_mag    = b_neg ? -D2 : D2;
    end

    // Shared shadow register: {upper accumulator/remainder, lower multiplier/quotient}.
    always_comb begin
        mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? opb : '0)};
        mul_next  = {mul_sum, prod[WIDTH-1:1]};
        div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  prod[WIDTH-2:0], 1'b1};
    end

    // MIN / -1 falls out naturally: magnitude quotient 2^(W-1) negates back to MIN.
    always_comb begin
        mul_fix = neg_lo ? -prod : prod;
        quo_fix = neg_lo ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
        rem_fix = neg_hi ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            opb     <= '0;
            prod    <= '0;
            is_div  <= 1'b0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
        end else if (Flush) begin
            state <= S_IDLE;
            cnt   <= '0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        if (div_zero) begin
                            DivZero <= 1'b1;
                        end else if (op_long) begin
                            state   <= S_RUN;
                            cnt     <= '0;
                            prod    <= {{WIDTH{1'b0}}, a_mag};
                            opb     <= b_mag;
                            is_div  <= op_div;
                            neg_lo  <= a_neg ^ b_neg;
                            neg_hi  <= op_div ? a_neg : (a_neg ^ b_neg);
                            DivZero <= 1'b0;
                        end else if (XALUOp == OP_MTHI) begin
                            hi      <= D1;
                            DivZero <= 1'b0;
                        end else if (XALUOp == OP_MTLO) begin
                            lo      <= D1;
                            DivZero <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    prod <= is_div ? div_next : mul_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= mul_fix[2*WIDTH-1:WIDTH];
                        lo <= mul_fix[WIDTH-1:0];
                    end
                    Done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        XALU_Out = '0;
        if (XALUOp == OP_MFHI) begin
            XALU_Out = hi;
        end else if (XALUOp == OP_MFLO) begin
            XALU_Out = lo;
        end
    end

endmodule

// File: tb/tb_xalu_iter.sv
// Bench for xalu_iter: WIDTH=32 and WIDTH=8 instances against a transaction-level HI/LO model.
// Directed literal checks first, then randomized traffic with flushes and resets.
module tb_xalu_iter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic [31:0] d1  [2];
    logic [31:0] d2  [2];
    logic [3:0]  op  [2];
    logic        st  [2];
    logic        fl  [2];
    logic [31:0] out0;
    logic [7:0]  out1;
    logic        busy [2];
    logic        done [2];
    logic        dz   [2];

    xalu_iter #(.WIDTH(32), .OP_W(4)) dut32 (
        .clk(clk), .reset(rst[0]), .D1(d1[0]), .D2(d2[0]), .XALUOp(op[0]),
        .Start(st[0]), .Flush(fl[0]), .XALU_Out(out0), .Busy(busy[0]),
        .Done(done[0]), .DivZero(dz[0])
    );

    xalu_iter #(.WIDTH(8), .OP_W(4)) dut8 (
        .clk(clk), .reset(rst[1]), .D1(d1[1][7:0]), .D2(d2[1][7:0]), .XALUOp(op[1]),
        .Start(st[1]), .Flush(fl[1]), .XALU_Out(out1), .Busy(busy[1]),
        .Done(done[1]), .DivZero(dz[1])
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%h want=%h t=%0t", nm, k, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] wmask(input int k);
        return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    // Golden arithmetic on w-bit operands using 64-bit native math.
    function automatic void ref_op(input int w, input logic [3:0] o, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] rh, output logic [31:0] rl);
        logic [31:0] mk;
        logic [63:0] ua, ub, p;
        longint      sa, sb, q, r;
        mk = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        ua = {32'd0, a & mk};
        ub = {32'd0, b & mk};
        sa = longint'(ua);
        sb = longint'(ub);
        if (a[w-1]) sa = sa - (longint'(1) << w);
        if (b[w-1]) sb = sb - (longint'(1) << w);
        if (o == 4'd1 || o == 4'd2) begin
            p  = (o == 4'd1) ? 64'(sa * sb) : ua * ub;
            rl = p[31:0] & mk;
            p  = p >> w;
            rh = p[31:0] & mk;
        end else begin
            if (o == 4'd7) begin
                q = sa / sb;
                r = sa % sb;
            end else begin
                q = longint'(ua / ub);
                r = longint'(ua % ub);
            end
            rl = q[31:0] & mk;
            rh = r[31:0] & mk;
        end
    endfunction

    logic [31:0] m_hi [2];
    logic [31:0] m_lo [2];
    logic [31:0] p_hi [2];
    logic [31:0] p_lo [2];
    int          left [2];
    bit          m_done [2];
    bit          m_dz [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_hi[k] = 0; m_lo[k] = 0; p_hi[k] = 0; p_lo[k] = 0;
            left[k] = 0; m_done[k] = 0; m_dz[k] = 0;
        end
    end

    // Model: a long op occupies the unit for w+1 cycles, then HI/LO take the golden result.
    always @(posedge clk) begin : model
        int w;
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 32 : 8;
            if (rst[k]) begin
                m_hi[k] = 0; m_lo[k] = 0; left[k] = 0; m_done[k] = 0; m_dz[k] = 0;
            end else begin
                m_done[k] = 0;
                if (fl[k]) begin
                    left[k] = 0;
                end else if (left[k] > 0) begin
                    left[k]--;
                    if (left[k] == 0) begin
                        m_hi[k] = p_hi[k];
                        m_lo[k] = p_lo[k];
                        m_done[k] = 1;
                    end
                end else if (st[k]) begin
                    case (op[k])
                        4'd1, 4'd2, 4'd7, 4'd8: begin
                            if ((op[k] == 4'd7 || op[k] == 4'd8) && (d2[k] & wmask(k)) == 0) begin
                                m_dz[k] = 1;
                            end else begin
                                m_dz[k] = 0;
                                ref_op(w, op[k], d1[k], d2[k], p_hi[k], p_lo[k]);
                                left[k] = w + 1;
                            end
                        end
                        4'd3: begin m_hi[k] = d1[k] & wmask(k); m_dz[k] = 0; end
                        4'd4: begin m_lo[k] = d1[k] & wmask(k); m_dz[k] = 0; end
                        default: ;
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [31:0] eo, ao;
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                eo = (op[k] == 4'd5) ? m_hi[k] : (op[k] == 4'd6) ? m_lo[k] : 32'd0;
                ao = (k == 0) ? out0 : {24'd0, out1};
                chk("xalu_out", k, ao, eo);
                chk("busy", k, {31'd0, busy[k]}, {31'd0, left[k] > 0});
                chk("done", k, {31'd0, done[k]}, {31'd0, m_done[k]});
                chk("divzero", k, {31'd0, dz[k]}, {31'd0, m_dz[k]});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int k, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        op[k] = o; d1[k] = a; d2[k] = b; st[k] = 1'b1;
        cyc();
        st[k] = 1'b0; op[k] = 4'd0; d1[k] = $urandom; d2[k] = $urandom;
    endtask

    task automatic wait_done(input int k, input int exp);
        int n;
        n = 0;
        while (done[k] !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
        chk("latency", k, n, exp);
    endtask

    task automatic expect_hilo(input string nm, input logic [31:0] eh, input logic [31:0] el);
        op[0] = 4'd5;
        @(negedge clk);
        chk({nm, "_hi"}, 0, out0, eh);
        cyc();
        op[0] = 4'd6;
        @(negedge clk);
        chk({nm, "_lo"}, 0, out0, el);
        cyc();
        op[0] = 4'd0;
    endtask

    function automatic logic [31:0] pick(input int k, input bit allow_zero);
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = (k == 0) ? 32'h8000_0000 : 32'h0000_0080;
            1: v = 32'hFFFF_FFFF;
            2: v = allow_zero ? 32'd0 : 32'd1;
            3: v = 32'd1;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; d1[k] = 0; d2[k] = 0; op[k] = 0; st[k] = 0; fl[k] = 0;
        end
        cyc();
        chk_on = 1'b1;
        cyc();
        rst[0] = 1'b0; rst[1] = 1'b0;
        chk("rst_busy", 0, {31'd0, busy[0]}, 32'd0);
        chk("rst_dz", 0, {31'd0, dz[0]}, 32'd0);
        expect_hilo("rst", 32'd0, 32'd0);

        issue(0, 4'd1, 32'hFFFF_FFFD, 32'd7);
        wait_done(0, 33);
        expect_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        issue(0, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0, 33);
        expect_hilo("multu", 32'hFFFF_FFFE, 32'h0000_0001);

        issue(0, 4'd7, 32'hFFFF_FFF9, 32'd2);
        wait_done(0, 33);
        expect_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(0, 4'd8, 32'h8000_0000, 32'h8000_0000);
        wait_done(0, 33);
        expect_hilo("divu", 32'd0, 32'd1);
        issue(0, 4'd7, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0, 33);
        expect_hilo("div_ovf", 32'd0, 32'h8000_0000);

        issue(0, 4'd3, 32'h0000_1234, 32'd0);
        issue(0, 4'd7, 32'd99, 32'd0);
        chk("dz_busy", 0, {31'd0, busy[0]}, 32'd0);
        chk("dz_flag", 0, {31'd0, dz[0]}, 32'd1);
        expect_hilo("dz", 32'h0000_1234, 32'h8000_0000);
        issue(0, 4'd4, 32'd5, 32'd0);
        chk("dz_clear", 0, {31'd0, dz[0]}, 32'd0);

        issue(0, 4'd1, 32'd5, 32'd6);
        repeat (9) cyc();
        fl[0] = 1'b1;
        cyc();
        fl[0] = 1'b0;
        chk("flush_busy", 0, {31'd0, busy[0]}, 32'd0);
        repeat (40) cyc();
        expect_hilo("flush", 32'h0000_1234, 32'd5);
        issue(0, 4'd1, 32'd5, 32'd6);
        repeat (32) cyc();
        chk("fix_busy", 0, {31'd0, busy[0]}, 32'd1);
        fl[0] = 1'b1;
        cyc();
        fl[0] = 1'b0;
        chk("fixflush_busy", 0, {31'd0, busy[0]}, 32'd0);
        chk("fixflush_done", 0, {31'd0, done[0]}, 32'd0);
        expect_hilo("fixflush", 32'h0000_1234, 32'd5);

        issue(0, 4'd1, 32'd3, 32'd5);
        repeat (3) cyc();
        issue(0, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0, 29);
        expect_hilo("ignored", 32'd0, 32'd15);

        issue(0, 4'd3, 32'd77, 32'd0);
        issue(0, 4'd7, 32'd100, 32'd3);
        repeat (5) cyc();
        rst[0] = 1'b1;
        op[0] = 4'd5;
        cyc();
        chk("rstmid_out", 0, out0, 32'd0);
        chk("rstmid_busy", 0, {31'd0, busy[0]}, 32'd0);
        chk("rstmid_done", 0, {31'd0, done[0]}, 32'd0);
        rst[0] = 1'b0;
        op[0] = 4'd0;

        // Small literal anchors for the 8-bit instance.
        issue(1, 4'd7, 32'h80, 32'hFF);
        wait_done(1, 9);
        op[1] = 4'd6;
        @(negedge clk);
        chk("w8_ovf_lo", 1, {24'd0, out1}, 32'h80);
        cyc();
        op[1] = 4'd0;

        for (int i = 0; i < 6000; i++) begin
            for (int k = 0; k < 2; k++) begin
                op[k]  = 4'($urandom_range(0, 10));
                st[k]  = 1'($urandom_range(0, 1));
                d1[k]  = pick(k, 1'b1);
                d2[k]  = pick(k, $urandom_range(0, 5) == 0);
                fl[k]  = ($urandom_range(0, 63) == 0);
                rst[k] = ($urandom_range(0, 1999) == 0);
            end
            cyc();
        end
        for (int k = 0; k < 2; k++) begin
            rst[k] = 0; st[k] = 0; fl[k] = 0; op[k] = 0;
        end
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
